hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble steering for a 5-stage pipe.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rsD,
  input  logic [2:0]  rtD,
  input  logic        rsVldD,
  input  logic        rtVldD,
  input  logic [2:0]  wrtRegX,
  input  logic        regWrtX,
  input  logic        readEnX,
  input  logic        brchTakenX,
  input  logic        memBusyM,
  input  logic        haltD,
  output logic        stallF,
  output logic        stallD,
  output logic        stallX,
  output logic        flushFD,
  output logic        bubbleX,
  output logic        bubbleW,
  output logic [2:0]  state,
  output logic [15:0] stallCnt,
  output logic [15:0] bubbleCnt
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [ST_W-1:0] S_RUN     = ST_W'(0);
  localparam logic [ST_W-1:0] S_FLUSH   = ST_W'(1);
  localparam logic [ST_W-1:0] S_MEMWAIT = ST_W'(2);
  localparam logic [ST_W-1:0] S_HALTED  = ST_W'(3);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next_state;
  logic            w_load_use;

  // Load in X feeding a register that D actually reads
  assign w_load_use = regWrtX & readEnX &
                      ((rsVldD & (rsD == wrtRegX)) | (rtVldD & (rtD == wrtRegX)));

  assign state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next_state;
  end

  // Next state: memory wait beats branch beats load-use beats halt
  always_comb begin
    w_next_state = S_RUN;
    case (r_state)
      S_RUN: begin
        if (memBusyM)        w_next_state = S_MEMWAIT;
        else if (brchTakenX) w_next_state = S_FLUSH;
        else if (w_load_use) w_next_state = S_RUN;
        else if (haltD)      w_next_state = S_HALTED;
        else                 w_next_state = S_RUN;
      end
      S_FLUSH:   w_next_state = memBusyM ? S_MEMWAIT : S_RUN;
      S_MEMWAIT: w_next_state = memBusyM ? S_MEMWAIT : S_RUN;
      S_HALTED:  w_next_state = S_HALTED;
      default:   w_next_state = S_RUN;
    endcase
  end

  // Control outputs are combinational so they act in the cycle the event appears
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallX  = 1'b0;
    flushFD = 1'b0;
    bubbleX = 1'b0;
    bubbleW = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (memBusyM) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            stallX  = 1'b1;
            bubbleW = 1'b1;
          end else if (brchTakenX) begin
            flushFD = 1'b1;
            bubbleX = 1'b1;
          end else if (w_load_use) begin
            stallF  = 1'b1;
            bubbleX = 1'b1;
          end
        end
        S_FLUSH, S_MEMWAIT: begin
          if (memBusyM) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            stallX  = 1'b1;
            bubbleW = 1'b1;
          end else if (r_state == S_FLUSH) begin
            flushFD = 1'b1;
          end
        end
        S_HALTED: begin
          stallF  = 1'b1;
          flushFD = 1'b1;
          stallX  = memBusyM;
          bubbleW = memBusyM;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating event counters; halted cycles are not counted as stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stallF && (r_state != S_HALTED) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bubbleX && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stallCnt  = r_stall_cnt;
  assign bubbleCnt = r_bubble_cnt;
`else
  assign stallCnt  = CNT_W'(0);
  assign bubbleCnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, halt/reset and saturation
// sequences, then random stimulus against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rsD, rtD, wrtRegX;
  logic        rsVldD, rtVldD, regWrtX, readEnX, brchTakenX, memBusyM, haltD;
  logic        stallF, stallD, stallX, flushFD, bubbleX, bubbleW;
  logic [2:0]  state;
  logic [15:0] stallCnt, bubbleCnt;

  int checks   = 0;
  int failures = 0;
  int m_stall  = 0;
  int m_bub    = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsVldD(rsVldD), .rtVldD(rtVldD),
    .wrtRegX(wrtRegX), .regWrtX(regWrtX), .readEnX(readEnX), .brchTakenX(brchTakenX),
    .memBusyM(memBusyM), .haltD(haltD), .stallF(stallF), .stallD(stallD),
    .stallX(stallX), .flushFD(flushFD), .bubbleX(bubbleX), .bubbleW(bubbleW),
    .state(state), .stallCnt(stallCnt), .bubbleCnt(bubbleCnt)
  );

  always #5 clk = ~clk;

  // out packing: {stallF, stallD, stallX, flushFD, bubbleX, bubbleW}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_MEM   = 6'b111001;
  localparam logic [5:0] O_BR    = 6'b000110;
  localparam logic [5:0] O_FL    = 6'b000100;
  localparam logic [5:0] O_LU    = 6'b100010;
  localparam logic [5:0] O_HALT  = 6'b100100;
  localparam logic [5:0] O_HALTM = 6'b101101;

  typedef struct {
    logic [2:0] rs, rt, wr;
    logic       rsv, rtv, rw, re, br, mb, hd;
    logic [5:0] exp_out;
    logic [2:0] exp_state;
  } vec_t;

  function automatic logic [5:0] outs();
    return {stallF, stallD, stallX, flushFD, bubbleX, bubbleW};
  endfunction

  function automatic logic [15:0] exp_cnt(input int v);
`ifdef HAZ_PERF_CNT_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rsD = v.rs; rtD = v.rt; wrtRegX = v.wr; rsVldD = v.rsv; rtVldD = v.rtv;
    regWrtX = v.rw; readEnX = v.re; brchTakenX = v.br; memBusyM = v.mb; haltD = v.hd;
  endtask

  function automatic vec_t mk(input logic rw, re, input logic [2:0] wr,
                              input logic [2:0] rs, input logic rsv,
                              input logic [2:0] rt, input logic rtv,
                              input logic br, mb, hd,
                              input logic [5:0] eo, input logic [2:0] es);
    vec_t v;
    v.rw = rw; v.re = re; v.wr = wr; v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv;
    v.br = br; v.mb = mb; v.hd = hd; v.exp_out = eo; v.exp_state = es;
    return v;
  endfunction

  // Account for this cycle's counter increments as seen at the coming edge
  task automatic count(input logic [5:0] o, input logic [2:0] st);
    if (o[5] && st != 3'd3 && m_stall < 65535) m_stall++;
    if (o[1] && m_bub < 65535) m_bub++;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, ".out"},   32'(outs()), 32'(v.exp_out));
    chk({name, ".state"}, 32'(state), 32'(v.exp_state));
    chk({name, ".cnt"},   {stallCnt, bubbleCnt}, {exp_cnt(m_stall), exp_cnt(m_bub)});
    count(v.exp_out, v.exp_state);
  endtask

  // Mid-cycle reset pulse with an event pending: outputs must clear at once
  task automatic reset_pulse(input string name);
    vec_t z;
    z = mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0);
    @(negedge clk);
    drive(z);
    memBusyM = 1'b1;
    rst = 1'b1;
    #1;
    chk({name, ".rst_out"},   32'(outs()), 32'(O_NONE));
    chk({name, ".rst_state"}, 32'(state), 32'd0);
    chk({name, ".rst_cnt"},   {stallCnt, bubbleCnt}, 32'd0);
    memBusyM = 1'b0;
    #1 rst = 1'b0;
    m_stall = 0;
    m_bub   = 0;
  endtask

  // Rule-level reference: pick the acting event, then look up its response
  function automatic void ref_model(input int st, input logic mb, br, lu, hd,
                                    output logic [5:0] o, output int nst);
    o = O_NONE;
    nst = 0;
    if (st == 3) begin
      o = mb ? O_HALTM : O_HALT;
      nst = 3;
    end else if (mb) begin
      if (st != 2 || mb) o = (st == 0 || st == 1 || st == 2) ? O_MEM : O_NONE;
      nst = 2;
    end else if (st == 1) begin
      o = O_FL;
    end else if (st == 2) begin
      o = O_NONE;
    end else if (br) begin
      o = O_BR;
      nst = 1;
    end else if (lu) begin
      o = O_LU;
    end else if (hd) begin
      nst = 3;
    end
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   st;
    int   nst;
    int   halted_for;
    logic [5:0] eo;
    logic lu;

    rst = 1'b1;
    drive(mk(0,0,0, 0,0, 0,0, 0,1,0, O_NONE, 3'd0));
    #3;
    chk("reset.out",   32'(outs()), 32'(O_NONE));
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.cnt",   {stallCnt, bubbleCnt}, 32'd0);
    memBusyM = 1'b0;
    #4 rst = 1'b0;

    // memory wait with branch held, then branch flush
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,1,0, O_MEM, (i == 0) ? 3'd0 : 3'd2));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,0,0, O_NONE, 3'd2));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,0,0, O_BR,   3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_FL,   3'd1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0));
    // load-use on rs, release, load-use on rt, non-load and unread matches
    tbl.push_back(mk(1,1,3, 3,1, 0,0, 0,0,0, O_LU,   3'd0));
    tbl.push_back(mk(0,0,3, 3,1, 0,0, 0,0,0, O_NONE, 3'd0));
    tbl.push_back(mk(1,1,5, 5,0, 5,1, 0,0,0, O_LU,   3'd0));
    tbl.push_back(mk(1,0,5, 5,1, 5,1, 0,0,0, O_NONE, 3'd0));
    tbl.push_back(mk(1,1,6, 6,0, 6,0, 0,0,0, O_NONE, 3'd0));
    tbl.push_back(mk(0,1,2, 2,1, 2,1, 0,0,0, O_NONE, 3'd0));
    // branch + halt + load-use together: branch only
    tbl.push_back(mk(1,1,4, 4,1, 4,1, 1,0,1, O_BR,   3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_FL,   3'd1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0));
    // memory busy arriving during FLUSH
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 1,0,0, O_BR,   3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,1,0, O_MEM,  3'd1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd2));
    // memory beats load-use; load-use beats halt
    tbl.push_back(mk(1,1,1, 1,1, 0,0, 0,1,0, O_MEM,  3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd2));
    tbl.push_back(mk(1,1,7, 0,0, 7,1, 0,0,1, O_LU,   3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // halt: drains forever until reset
    apply(mk(0,0,0, 0,0, 0,0, 0,0,1, O_NONE, 3'd0), "halt_enter");
    for (int i = 0; i < 20; i++)
      apply(mk(0,0,0, 0,0, 0,0, 1,0,0, O_HALT, 3'd3), $sformatf("halted%0d", i));
    apply(mk(0,0,0, 0,0, 0,0, 0,1,0, O_HALTM, 3'd3), "halted_mem");
    reset_pulse("halt_rst");
    apply(mk(0,0,0, 0,0, 0,0, 0,0,0, O_NONE, 3'd0), "post_rst");

    // random stimulus against the reference model
    st = 0;
    halted_for = 0;
    for (int i = 0; i < 2000; i++) begin
      v.rs = 3'($urandom); v.rt = 3'($urandom); v.wr = 3'($urandom);
      v.rsv = 1'($urandom); v.rtv = 1'($urandom);
      v.rw = 1'($urandom); v.re = 1'($urandom);
      v.br = ($urandom_range(0, 3) == 0);
      v.mb = ($urandom_range(0, 3) == 0);
      v.hd = ($urandom_range(0, 31) == 0);
      lu = v.rw && v.re && ((v.rsv && v.rs == v.wr) || (v.rtv && v.rt == v.wr));
      ref_model(st, v.mb, v.br, lu, v.hd, eo, nst);
      v.exp_out = eo;
      v.exp_state = 3'(st);
      apply(v, "rand");
      st = nst;
      halted_for = (st == 3) ? halted_for + 1 : 0;
      if (halted_for > 4) begin
        reset_pulse("rand_rst");
        st = 0;
        halted_for = 0;
      end
    end

    // counter saturation under a long memory wait
    reset_pulse("sat_rst");
    @(negedge clk);
    memBusyM = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat.stallCnt",  32'(stallCnt),  32'(exp_cnt(65535)));
    chk("sat.bubbleCnt", 32'(bubbleCnt), 32'd0);
    chk("sat.out",       32'(outs()),    32'(O_MEM));
    chk("sat.state",     32'(state),     32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
